tff_bank_sequencer: RTL and testbench

Sequencer for a bank of `WIDTH` T flip-flops.
- Accepts one command at a time over a valid/ready handshake: load a value, count up, count down, or clear.
- Drives only the per-bit toggle enables; the bank holds all state.
- Sits between the command source (switch/debounce logic or a test driver) and the binary-to-octal display path, which consumes `q`.

---
 rtl/tff_bank_sequencer_pkg.sv | 26 ++
 rtl/tff_cell.sv | 40 ++++
 rtl/tff_bank_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_tff_bank_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_bank_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tff_bank_sequencer_pkg
//
// Shared definitions for the T flip-flop bank sequencer:
//   - command op codes carried on cmd_op
//   - sequencer state encoding (2-bit register)
//
// No ports; imported by the sequencer top.
// -----------------------------------------------------------------------------
package tff_bank_sequencer_pkg;

   // Command op codes on cmd_op.
   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_UP    = 2'd1;
   localparam logic [1:0] OP_DOWN  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   // Sequencer states. The encoding is also what state_dbg exposes.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage : tff_bank_sequencer_pkg

// File: rtl/tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
//
// One T flip-flop of the bank. The stored bit inverts on a rising clock edge
// when t is 1 and holds otherwise.
//
// Ports:
//   clk    in  1  clock, rising edge active
//   reset  in  1  asynchronous reset, active low (clears q)
//   t      in  1  toggle enable
//   q      out 1  stored bit
// -----------------------------------------------------------------------------
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (t) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tff_bank_sequencer
//
// Sequencer for a bank of WIDTH T flip-flops. Takes one command at a time
// (LOAD, COUNT_UP, COUNT_DOWN, CLEAR) and drives only the per-bit toggle
// enables t_vec; the bank of tff_cell instances holds all state and its
// outputs are q. q feeds the binary-to-octal display path downstream.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_op and cmd_data are captured at that edge and later input changes have
// no effect. cmd_ready is high only in IDLE and depends on registered state
// alone, so there is no combinational path from cmd_valid to cmd_ready. A
// source that sees cmd_ready low must hold cmd_valid and its payload.
//
// Ports:
//   clk        in   1      clock, rising edge active
//   reset      in   1      asynchronous reset, active low
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted (IDLE only)
//   cmd_op     in   2      0 LOAD, 1 COUNT_UP, 2 COUNT_DOWN, 3 CLEAR
//   cmd_data   in   WIDTH  LOAD target / COUNT step count / ignored for CLEAR
//   abort      in   1      stops an active count (ignored outside COUNT)
//   busy       out  1      command in progress (any state but IDLE)
//   done       out  1      one-cycle completion pulse
//   t_vec      out  WIDTH  toggle enables applied to the bank this cycle
//   q          out  WIDTH  current bank state
//   state_dbg  out  2      current sequencer state encoding
//
// WIDTH must be at least 2; a multiple of 3 gives whole octal digits.
// -----------------------------------------------------------------------------
module tff_bank_sequencer
   import tff_bank_sequencer_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q,
   output logic [1:0]       state_dbg
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Toggle pattern that makes a T bank count up by one: bit i toggles when
   // every lower bit is 1. All-ones toggles every bit, giving the wrap to 0.
   function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      logic             carry;
      carry = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         r[i]  = carry;
         carry = carry & v[i];
      end
      return r;
   endfunction

   // Count down by one: bit i toggles when every lower bit is 0. Zero toggles
   // every bit, giving the wrap to all-ones.
   function automatic logic [WIDTH-1:0] down_toggles(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      logic             borrow;
      borrow = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         r[i]   = borrow;
         borrow = borrow & ~v[i];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [1:0]       op_q,    op_d;
   // Holds the LOAD target in APPLY, or the remaining step count in COUNT.
   logic [WIDTH-1:0] data_q,  data_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      t_vec   = '0;
      done    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
                  state_d = ST_APPLY;
               end else if (cmd_data != '0) begin
                  state_d = ST_COUNT;
               end else begin
                  // Zero-step count: nothing to toggle, complete next cycle.
                  state_d = ST_DONE;
               end
            end
         end

         ST_APPLY: begin
            // Toggling exactly the differing bits lands the bank on the target
            // in one edge; CLEAR is a load of zero, so it toggles the set bits.
            if (op_q == OP_CLEAR) begin
               t_vec = q;
            end else begin
               t_vec = q ^ data_q;
            end
            state_d = ST_DONE;
         end

         ST_COUNT: begin
            if (abort) begin
               // Abort suppresses this cycle's toggle and drops the rest.
               data_d  = '0;
               state_d = ST_DONE;
            end else begin
               if (op_q == OP_UP) begin
                  t_vec = up_toggles(q);
               end else begin
                  t_vec = down_toggles(q);
               end
               data_d = data_q - ONE;
               if (data_q == ONE) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

   // ---------------------------------------------------------------------------
   // The bank
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < WIDTH; g++) begin : g_bank
      tff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .t     (t_vec[g]),
         .q     (q[g])
      );
   end

endmodule : tff_bank_sequencer

// File: tb/tb_tff_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tff_bank_sequencer
//
// Directed bench for tff_bank_sequencer. Each issued command pushes its
// expected final bank value onto exp_q; the value is popped and compared
// against q in the cycle the DUT raises done. Cycle-level details (t_vec,
// intermediate q, handshake outputs) are checked inline.
// -----------------------------------------------------------------------------
module tb_tff_bank_sequencer;
   import tff_bank_sequencer_pkg::*;

   localparam int WIDTH = 9;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] q;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   tff_bank_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .t_vec     (t_vec),
      .q         (q),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                      input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command from IDLE; returns just after the accepting edge.
   // The payload is scrambled afterwards, which must not affect the command.
   task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [WIDTH-1:0] exp_final);
      chk("ready_before_issue", {{(WIDTH-1){1'b0}}, cmd_ready}, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      exp_q.push_back(exp_final);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
   endtask

   // Expect done now and compare q with the oldest scoreboard entry.
   task automatic check_done(input string tag);
      chk({tag, "_done"}, {{(WIDTH-1){1'b0}}, done}, 1);
      chk({tag, "_tvec_at_done"}, t_vec, 0);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
         n_err++;
         $error("FAIL %s_sb: observed empty queue expected an entry", tag);
      end
      if (exp_q.size() > 0) begin
         chk({tag, "_q"}, q, exp_q.pop_front());
      end
   endtask

   // Wait up to max_cycles for done, then check it.
   task automatic wait_done(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check_done(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_data  = '0;
      abort     = 1'b0;

      // Reset values.
      #1;
      chk("rst_q", q, 0);
      chk("rst_tvec", t_vec, 0);
      chk("rst_busy", {{(WIDTH-1){1'b0}}, busy}, 0);
      chk("rst_done", {{(WIDTH-1){1'b0}}, done}, 0);
      chk("rst_ready", {{(WIDTH-1){1'b0}}, cmd_ready}, 1);
      chk("rst_state", {7'd0, state_dbg}, {7'd0, ST_IDLE});
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;

      // Reset dropped in the middle of a COUNT_UP.
      issue(OP_UP, 9'd100, 9'd100);
      repeat (3) tick();
      chk("cnt_before_rst_q", q, 9'd3);
      chk("cnt_before_rst_busy", {{(WIDTH-1){1'b0}}, busy}, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_q", q, 0);
      chk("async_rst_busy", {{(WIDTH-1){1'b0}}, busy}, 0);
      chk("async_rst_ready", {{(WIDTH-1){1'b0}}, cmd_ready}, 1);
      chk("async_rst_done", {{(WIDTH-1){1'b0}}, done}, 0);
      exp_q.delete();
      tick();
      chk("held_rst_done", {{(WIDTH-1){1'b0}}, done}, 0);
      chk("held_rst_q", q, 0);
      @(negedge clk) reset = 1'b1;
      issue(OP_LOAD, 9'o017, 9'o017);
      wait_done("load_017", 4);
      tick();

      // CLEAR from 017.
      issue(OP_CLEAR, 9'o000, 9'o000);
      chk("clear_017_tvec", t_vec, 9'o017);
      tick();
      check_done("clear_017");
      tick();

      // LOAD 527 from 0; abort held during APPLY must be ignored.
      issue(OP_LOAD, 9'o527, 9'o527);
      abort = 1'b1;
      #1;
      chk("load527_tvec", t_vec, 9'o527);
      chk("load527_state", {7'd0, state_dbg}, {7'd0, ST_APPLY});
      chk("load527_ready", {{(WIDTH-1){1'b0}}, cmd_ready}, 0);
      chk("load527_busy", {{(WIDTH-1){1'b0}}, busy}, 1);
      tick();
      abort = 1'b0;
      check_done("load527");
      tick();
      chk("load527_done_low", {{(WIDTH-1){1'b0}}, done}, 0);
      chk("load527_ready_back", {{(WIDTH-1){1'b0}}, cmd_ready}, 1);

      // LOAD of the current value: no toggles, done still pulses.
      issue(OP_LOAD, 9'o527, 9'o527);
      chk("load_same_tvec", t_vec, 0);
      tick();
      check_done("load_same");
      tick();

      // COUNT_UP 3 from 776 across the wrap.
      issue(OP_LOAD, 9'o776, 9'o776);
      tick();
      check_done("load776");
      tick();
      issue(OP_UP, 9'd3, 9'o001);
      chk("up3_tvec0", t_vec, 9'o001);
      chk("up3_state", {7'd0, state_dbg}, {7'd0, ST_COUNT});
      tick();
      chk("up3_q1", q, 9'o777);
      chk("up3_wrap_tvec", t_vec, 9'o777);
      tick();
      chk("up3_q2", q, 9'o000);
      chk("up3_tvec2", t_vec, 9'o001);
      chk("up3_done_early", {{(WIDTH-1){1'b0}}, done}, 0);
      tick();
      check_done("up3");
      tick();

      // COUNT_DOWN 2 from 0.
      issue(OP_CLEAR, 9'o000, 9'o000);
      tick();
      check_done("clear_001");
      tick();
      issue(OP_DOWN, 9'd2, 9'o776);
      chk("down2_tvec0", t_vec, 9'o777);
      tick();
      chk("down2_q1", q, 9'o777);
      chk("down2_tvec1", t_vec, 9'o001);
      tick();
      check_done("down2");
      tick();

      // CLEAR from 777 (count up one step first).
      issue(OP_UP, 9'd1, 9'o777);
      tick();
      check_done("up1");
      tick();
      issue(OP_CLEAR, 9'o123, 9'o000);
      chk("clear_777_tvec", t_vec, 9'o777);
      tick();
      check_done("clear_777");
      tick();

      // COUNT_UP 100 aborted on the 6th count edge.
      issue(OP_UP, 9'd100, 9'd5);
      repeat (5) tick();
      chk("abort_pre_q", q, 9'd5);
      chk("abort_pre_state", {7'd0, state_dbg}, {7'd0, ST_COUNT});
      abort = 1'b1;
      #1;
      chk("abort_tvec", t_vec, 0);
      tick();
      abort = 1'b0;
      check_done("abort");
      tick();
      repeat (3) tick();
      chk("abort_post_q", q, 9'd5);
      chk("abort_post_done", {{(WIDTH-1){1'b0}}, done}, 0);
      chk("abort_post_busy", {{(WIDTH-1){1'b0}}, busy}, 0);

      // cmd_valid held with LOAD 1 while a COUNT_UP 2 runs.
      issue(OP_UP, 9'd2, 9'd7);
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_data  = 9'o001;
      #1;
      chk("held_ready0", {{(WIDTH-1){1'b0}}, cmd_ready}, 0);
      tick();
      chk("held_q6", q, 9'd6);
      chk("held_ready1", {{(WIDTH-1){1'b0}}, cmd_ready}, 0);
      tick();
      check_done("held_up2");
      chk("held_ready2", {{(WIDTH-1){1'b0}}, cmd_ready}, 0);
      tick();
      chk("held_ready_idle", {{(WIDTH-1){1'b0}}, cmd_ready}, 1);
      exp_q.push_back(9'o001);
      tick();
      cmd_valid = 1'b0;
      chk("held_apply_state", {7'd0, state_dbg}, {7'd0, ST_APPLY});
      chk("held_apply_tvec", t_vec, 9'o006);
      tick();
      check_done("held_load1");
      repeat (3) tick();
      chk("held_once_q", q, 9'o001);
      chk("held_once_busy", {{(WIDTH-1){1'b0}}, busy}, 0);

      // COUNT_UP 0: done right after accept, q unchanged.
      issue(OP_UP, 9'd0, 9'o001);
      chk("up0_state", {7'd0, state_dbg}, {7'd0, ST_DONE});
      check_done("up0");
      tick();
      chk("up0_done_low", {{(WIDTH-1){1'b0}}, done}, 0);
      chk("up0_q", q, 9'o001);

      chk("sb_empty", WIDTH'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_tff_bank_sequencer
